// File: rtl/yarp_encode.sv
// yarp_encode: packs RV32I fields into instruction words and streams them to imem through a small FIFO
module yarp_encode #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            base_load_i,
    input  logic [XLEN-1:0] base_addr_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_fmt_i,
    input  logic [6:0]      req_op_i,
    input  logic [4:0]      req_rd_i,
    input  logic [4:0]      req_rs1_i,
    input  logic [4:0]      req_rs2_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [6:0]      req_funct7_i,
    input  logic [31:0]     req_imm_i,
    output logic            wr_valid_o,
    input  logic            wr_ready_i,
    output logic [XLEN-1:0] wr_addr_o,
    output logic [31:0]     wr_data_o,
    output logic            err_o,
    output logic [1:0]      err_code_o,
    input  logic            err_clr_i,
    output logic [15:0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic [31:0] imm, word;
    logic [1:0]  code;
    logic        fits12, fits13, fits21, accept, push, pop;
    assign imm    = req_imm_i;
    assign fits12 = imm == {{20{imm[11]}}, imm[11:0]};
    assign fits13 = imm == {{19{imm[12]}}, imm[12:0]};
    assign fits21 = imm == {{11{imm[20]}}, imm[20:0]};
    assign word =
        req_fmt_i == 3'd0 ? {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_op_i} :
        req_fmt_i == 3'd1 ? {imm[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_op_i} :
        req_fmt_i == 3'd2 ? {imm[11:5], req_rs2_i, req_rs1_i, req_funct3_i, imm[4:0], req_op_i} :
        req_fmt_i == 3'd3 ? {imm[12], imm[10:5], req_rs2_i, req_rs1_i, req_funct3_i, imm[4:1], imm[11], req_op_i} :
        req_fmt_i == 3'd4 ? {imm[31:12], req_rd_i, req_op_i} :
                            {imm[20], imm[10:1], imm[11], imm[19:12], req_rd_i, req_op_i};
    // range failures outrank alignment failures
    assign code =
        req_fmt_i[2:1] == 2'b11                ? 2'd1 :
        req_fmt_i == 3'd1 || req_fmt_i == 3'd2 ? (fits12 ? 2'd0 : 2'd2) :
        req_fmt_i == 3'd3                      ? (!fits13 ? 2'd2 : imm[0] ? 2'd3 : 2'd0) :
        req_fmt_i == 3'd5                      ? (!fits21 ? 2'd2 : imm[0] ? 2'd3 : 2'd0) :
        req_fmt_i == 3'd4 && imm[11:0] != '0   ? 2'd3 : 2'd0;
    assign req_ready_o = !(wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0]);
    assign wr_valid_o  = wp != rp;
    assign wr_data_o   = wr_valid_o ? mem[rp[AW-1:0]] : '0;
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && code == 2'd0;
    assign pop         = wr_valid_o && wr_ready_i;
    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= word;
    always_ff @(posedge clk) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            wr_addr_o  <= '0;
            err_o      <= 1'b0;
            err_code_o <= 2'd0;
            count_o    <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                rp      <= rp + 1'b1;
                count_o <= &count_o ? count_o : count_o + 16'd1;
            end
            wr_addr_o <= base_load_i ? base_addr_i & ~XLEN'(3) : pop ? wr_addr_o + XLEN'(4) : wr_addr_o;
            if (accept && code != 2'd0 && (!err_o || err_clr_i)) begin
                err_o      <= 1'b1;
                err_code_o <= code;
            end else if (err_clr_i) begin
                err_o      <= 1'b0;
                err_code_o <= 2'd0;
            end
        end
    end
endmodule

// File: doc/yarp_encode.md
Name: yarp_encode

Overview:
- Instruction encoder and program writer: the inverse of the yarp decode stage.
- Accepts field-level encode requests (format, opcode, rd/rs1/rs2, funct3/funct7, 32-bit immediate) and packs each into a 32-bit RV32I instruction word.
- Range- and alignment-checks the immediate; legal words are buffered and streamed to the instruction-memory write port with an auto-incrementing address.
- Used by the boot loader / test-program injector to fill imem ahead of the core.

Parameters:
- XLEN, 32, address and data width (from yarp_pkg).
- DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- base_load_i  input  1  load write-address register
- base_addr_i  input  XLEN  new base address (word aligned; bits[1:0] forced to 0)
- req_valid_i  input  1  encode request valid
- req_ready_o  output  1  encoder can accept request
- req_fmt_i  input  3  0=R,1=I,2=S,3=B,4=U,5=J,6/7 illegal
- req_op_i  input  7  opcode
- req_rd_i  input  5  rd
- req_rs1_i  input  5  rs1
- req_rs2_i  input  5  rs2
- req_funct3_i  input  3  funct3
- req_funct7_i  input  7  funct7 (R only)
- req_imm_i  input  32  immediate, signed byte offset / value
- wr_valid_o  output  1  imem write valid
- wr_ready_i  input  1  imem write accepted
- wr_addr_o  output  XLEN  write address
- wr_data_o  output  32  encoded instruction
- err_o  output  1  sticky error flag
- err_code_o  output  2  1=bad fmt, 2=imm range, 3=misaligned imm
- err_clr_i  input  1  clear err_o/err_code_o
- count_o  output  16  words written since reset (saturating)

Behaviour:
- Reset (sync): FIFO empty, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, err_o=0, err_code_o=0, count_o=0. req_ready_o=1 the cycle after reset deasserts. An in-flight FIFO is discarded.
- req_ready_o = (fifo count < DEPTH), registered-state only; no combinational path from wr_ready_i.
- Request accept: req_valid_i & req_ready_o. The word is encoded combinationally and pushed the same edge. Earliest wr_valid_o is the next cycle (latency 1).
- Packing, unused fields are ignored:
  - R: {f7,rs2,rs1,f3,rd,op}
  - I: {imm[11:0],rs1,f3,rd,op}
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
  - U: {imm[31:12],rd,op}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
- Legality checks, evaluated in this priority order:
  - fmt 6/7 -> code 1.
  - I/S: imm must equal sign-extension of imm[11:0], else code 2.
  - B: imm must fit 13-bit signed, else code 2; then imm[0] must be 0, else code 3.
  - J: imm must fit 21-bit signed, else code 2; then imm[0] must be 0, else code 3.
  - U: imm[11:0] must be 0, else code 3.
- An illegal request is still accepted (handshake completes) but is not pushed. err_o is set and err_code_o captures the first error only; later errors do not overwrite it while err_o=1.
- err_clr_i clears the flag; err_clr_i plus a new error in the same cycle -> the new error is captured.
- Output: wr_valid_o = FIFO non-empty; wr_data_o = FIFO head; wr_addr_o = address register. wr_data_o and wr_addr_o must stay stable while wr_valid_o & !wr_ready_i.
- On a write handshake: pop, address += 4 (wraps mod 2^XLEN), count_o += 1 (saturates at 0xFFFF).
- base_load_i: address <= {base_addr_i[XLEN-1:2],2'b00}. It takes priority over the +4 in the same cycle. It applies to the current head and all later words; FIFO contents are unaffected.
- Simultaneous push and pop: allowed at any occupancy below DEPTH, and the count is unchanged. When full, push is blocked even if a pop occurs.
- FIFO pointers are log2(DEPTH)+1 bits with natural wrap.

Test Plan:
- I fmt, op 0x13, rd1, rs1 0, f3 0, imm 5, wr_ready_i=1 -> one write, addr 0x0, data 0x00500093, count_o=1.
- Back-to-back R (op 0x33, rd3, rs1 1, rs2 2, f7 0) then S (op 0x23, rs1 1, rs2 2, f3 2, imm 8) -> data 0x002081B3 @0x0, then 0x0020A423 @0x4.
- base_load 0x80000000, then B (op 0x63, rs1 1, rs2 2, f3 0, imm -4), J (op 0x6F, rd1, imm 0x800), U (op 0x37, rd5, imm 0x12345000):
  - data 0xFE208EE3 @0x80000000
  - data 0x001000EF @0x80000004
  - data 0x123452B7 @0x80000008
- Errors:
  - I imm 2048 -> accepted, no write, err_o=1, code 2.
  - Then B imm 3 -> code stays 2.
  - Then err_clr_i -> err_o=0.
  - Then fmt 7 -> code 1.
- Backpressure: wr_ready_i=0, 5 requests -> req_ready_o low after the 4th. Data/addr hold stable. Release -> 4 writes at consecutive addresses, then the 5th is accepted.
- Reset asserted with 3 words queued -> next cycle wr_valid_o=0, wr_addr_o=0, count_o=0, err_o=0.
